// File: rtl/dpram_loader_pkg.sv
// Shared types and constants for the dpram loader.
//   state_t      : loader FSM states
//   IOCTL_ADDR_W : width of the HPS ioctl byte address
//   CKSUM_W      : width of the additive checksum
package dpram_loader_pkg;
  localparam int IOCTL_ADDR_W = 25;
  localparam int CKSUM_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/dpram_loader_cksum.sv
// Registered accumulator: o_sum <= o_sum + zero-extended i_d when i_en.
// Used both for the byte checksum and (with i_d = 1) the byte counter.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : accumulate i_d this cycle
//   i_d        : addend, DW bits, zero-extended (truncated if DW > W)
//   o_sum      : accumulated value, W bits, wraps mod 2**W
module dpram_loader_cksum #(
  parameter int W  = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [W-1:0]  o_sum
);
  logic [W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_sum <= '0;
    else if (i_en)      r_sum <= r_sum + W'(i_d);
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/dpram_loader.sv
// HPS ioctl download -> dpram port A write initiator.
// Each accepted download byte becomes one registered write on port A; after
// the download it optionally zero-fills the RAM above the highest written
// address, then flags done with a byte count and mod-2^16 checksum.
// Optional build macro: DPRAM_LOADER_VERIFY_EN (read-back verify of every
// load write, adds the verify_err output).
//   clk, reset       : clock, synchronous active-high reset
//   ioctl_download   : high for the whole transfer (rising edge starts a load)
//   ioctl_wr         : one-cycle byte strobe
//   ioctl_addr       : byte address of ioctl_dout
//   ioctl_dout       : download byte
//   ioctl_wait       : stall to the HPS (tail fill / verify read-back)
//   mem_ce/wr/addr/din : dpram port A controls
//   mem_dout         : dpram port A read data (verify build only)
//   verify_err       : sticky read-back mismatch (verify build only)
//   busy             : load or fill in progress
//   done             : sticky, load completed
//   overflow         : sticky, a byte was addressed past the RAM
//   byte_count       : bytes written during the load
//   checksum         : mod-2^16 sum of the written bytes
module dpram_loader
  import dpram_loader_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int ADDR       = 14,
  parameter int CLEAR_TAIL = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [DATA-1:0]         ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    mem_ce,
  output logic                    mem_wr,
  output logic [ADDR-1:0]         mem_addr,
  output logic [DATA-1:0]         mem_din,
  input  logic [DATA-1:0]         mem_dout,
`ifdef DPRAM_LOADER_VERIFY_EN
  output logic                    verify_err,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [ADDR:0]           byte_count,
  output logic [CKSUM_W-1:0]      checksum
);
  localparam logic [ADDR-1:0] LAST = '1;

  state_t            r_state, w_state_nxt;
  logic              r_dl_q;
  logic              r_hw_vld;     // at least one byte landed this load
  logic [ADDR-1:0]   r_hw;         // highest address written this load
  logic [ADDR-1:0]   r_clr_addr;   // address currently on the port during CLEAR
  logic              r_mem_ce, r_mem_wr;
  logic [ADDR-1:0]   r_mem_addr;
  logic [DATA-1:0]   r_mem_din;
  logic              r_done, r_ovf;

  logic              w_dl_rise, w_in_range, w_strobe, w_accept, w_ovf_hit;
  logic              w_start, w_load_end, w_fill;
  logic [ADDR-1:0]   w_fill_start;
  logic              w_stall, w_vbusy, w_vrd;

  assign w_dl_rise  = ioctl_download & ~r_dl_q;
  assign w_in_range = (ioctl_addr[IOCTL_ADDR_W-1:ADDR] == '0);
  // strobes during a stall are protocol errors and are dropped
  assign w_strobe   = (r_state == LOAD) & ioctl_wr & ~w_stall;
  assign w_accept   = w_strobe & w_in_range;
  assign w_ovf_hit  = w_strobe & ~w_in_range;
  assign w_start    = (r_state != LOAD) & (w_state_nxt == LOAD);
  // a strobe on the falling cycle keeps LOAD one more cycle so its write
  // is on the port before CLEAR/DONE take over the outputs
  assign w_load_end = ~ioctl_download & ~w_accept & ~w_vbusy;
  assign w_fill       = (CLEAR_TAIL != 0) && (!r_hw_vld || r_hw != LAST);
  assign w_fill_start = r_hw_vld ? r_hw + ADDR'(1) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_dl_rise) w_state_nxt = LOAD;
      LOAD:    if (w_load_end) w_state_nxt = w_fill ? CLEAR : DONE;
      CLEAR:   if (w_dl_rise) w_state_nxt = LOAD;
               else if (r_clr_addr == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_dl_rise ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dl_q     <= 1'b0;
      r_hw_vld   <= 1'b0;
      r_hw       <= '0;
      r_clr_addr <= '0;
      r_mem_ce   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dl_q   <= ioctl_download;
      r_mem_ce <= w_vrd;   // read-back cycle keeps addr, wr low
      r_mem_wr <= 1'b0;
      if (w_start) begin
        r_hw_vld <= 1'b0;
        r_hw     <= '0;
        r_done   <= 1'b0;
        r_ovf    <= 1'b0;
      end
      if (w_accept) begin
        r_mem_ce   <= 1'b1;
        r_mem_wr   <= 1'b1;
        r_mem_addr <= ioctl_addr[ADDR-1:0];
        r_mem_din  <= ioctl_dout;
        r_hw_vld   <= 1'b1;
        if (!r_hw_vld || ioctl_addr[ADDR-1:0] > r_hw) r_hw <= ioctl_addr[ADDR-1:0];
      end
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (r_state == LOAD && w_state_nxt == CLEAR) begin
        r_clr_addr <= w_fill_start;
        r_mem_ce   <= 1'b1;
        r_mem_wr   <= 1'b1;
        r_mem_addr <= w_fill_start;
        r_mem_din  <= '0;
      end
      // stop at LAST: the counter never wraps back to 0
      if (r_state == CLEAR && w_state_nxt == CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR'(1);
        r_mem_ce   <= 1'b1;
        r_mem_wr   <= 1'b1;
        r_mem_addr <= r_clr_addr + ADDR'(1);
        r_mem_din  <= '0;
      end
      if (w_state_nxt == DONE) r_done <= 1'b1;
    end
  end

`ifdef DPRAM_LOADER_VERIFY_EN
  // [0] write on port, [1] read on port, [2] read data on mem_dout
  logic [2:0]      r_vld_pipe;
  logic [DATA-1:0] r_vdata;
  logic            r_verr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_vdata    <= '0;
      r_verr     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], w_accept};
      if (w_accept) r_vdata <= ioctl_dout;
      if (r_vld_pipe[2] && mem_dout != r_vdata) r_verr <= 1'b1;
    end
  end

  assign w_stall    = |r_vld_pipe[1:0];
  assign w_vbusy    = |r_vld_pipe;
  assign w_vrd      = r_vld_pipe[0];
  assign verify_err = r_verr;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^mem_dout;
  assign w_stall = 1'b0;
  assign w_vbusy = 1'b0;
  assign w_vrd   = 1'b0;
`endif

  dpram_loader_cksum #(.W(CKSUM_W), .DW(DATA)) u_cksum (
    .clk(clk), .reset(reset), .i_clr(w_start), .i_en(w_accept),
    .i_d(ioctl_dout), .o_sum(checksum)
  );

  dpram_loader_cksum #(.W(ADDR+1), .DW(1)) u_bcnt (
    .clk(clk), .reset(reset), .i_clr(w_start), .i_en(w_accept),
    .i_d(1'b1), .o_sum(byte_count)
  );

  assign ioctl_wait = (r_state == CLEAR) | w_stall;
  assign busy       = (r_state == LOAD) | (r_state == CLEAR);
  assign done       = r_done;
  assign overflow   = r_ovf;
  assign mem_ce     = r_mem_ce;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
endmodule

// File: tb/tb_dpram_loader.sv
// Bench for dpram_loader: instance A (ADDR=4, tail fill on) and instance B
// (ADDR=14, tail fill off) share one ioctl stream. A reference model tracks
// expected RAM contents, counts, checksums and overflow from the download
// rules; observed port-A writes are collected into shadow RAMs.
module tb_dpram_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  dout_a = '0, dout_b = '0;

  logic        a_wait, a_ce, a_wr, a_busy, a_done, a_ovf;
  logic [3:0]  a_addr;
  logic [7:0]  a_din;
  logic [4:0]  a_bc;
  logic [15:0] a_ck;
  logic        b_wait, b_ce, b_wr, b_busy, b_done, b_ovf;
  logic [13:0] b_addr;
  logic [7:0]  b_din;
  logic [14:0] b_bc;
  logic [15:0] b_ck;

  dpram_loader #(.DATA(8), .ADDR(4), .CLEAR_TAIL(1)) u_a (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(a_wait),
    .mem_ce(a_ce), .mem_wr(a_wr), .mem_addr(a_addr), .mem_din(a_din), .mem_dout(dout_a),
    .busy(a_busy), .done(a_done), .overflow(a_ovf), .byte_count(a_bc), .checksum(a_ck)
  );

  dpram_loader #(.DATA(8), .ADDR(14), .CLEAR_TAIL(0)) u_b (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(b_wait),
    .mem_ce(b_ce), .mem_wr(b_wr), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(dout_b),
    .busy(b_busy), .done(b_done), .overflow(b_ovf), .byte_count(b_bc), .checksum(b_ck)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model
  logic [7:0] a_mem [16];    bit a_known [16];
  logic [7:0] b_mem [16384]; bit b_known [16384];
  int a_hw, e_cnt_a, e_sum_a, e_cnt_b, e_sum_b;
  bit e_ovf_a, e_ovf_b;

  // observed RAM contents
  logic [7:0] shadow_a [16];
  logic [7:0] shadow_b [16384];

  always @(negedge clk) begin
    if (a_wr === 1'b1) shadow_a[a_addr] = a_din;
    if (b_wr === 1'b1) shadow_b[b_addr] = b_din;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_a_busy"}, a_busy, 0); chk({pfx, "_a_done"}, a_done, 0);
    chk({pfx, "_a_ovf"}, a_ovf, 0);   chk({pfx, "_a_wr"}, a_wr, 0);
    chk({pfx, "_a_ce"}, a_ce, 0);     chk({pfx, "_a_wait"}, a_wait, 0);
    chk({pfx, "_a_addr"}, a_addr, 0); chk({pfx, "_a_din"}, a_din, 0);
    chk({pfx, "_a_bc"}, a_bc, 0);     chk({pfx, "_a_ck"}, a_ck, 0);
    chk({pfx, "_b_busy"}, b_busy, 0); chk({pfx, "_b_done"}, b_done, 0);
    chk({pfx, "_b_wr"}, b_wr, 0);     chk({pfx, "_b_addr"}, b_addr, 0);
    chk({pfx, "_b_bc"}, b_bc, 0);     chk({pfx, "_b_ck"}, b_ck, 0);
  endtask

  task automatic model_clear();
    a_hw = -1; e_cnt_a = 0; e_sum_a = 0; e_cnt_b = 0; e_sum_b = 0;
    e_ovf_a = 0; e_ovf_b = 0;
  endtask

  task automatic begin_load();
    ioctl_download = 1'b1;
    @(negedge clk);
    model_clear();
    chk("start_busy_a", a_busy, 1); chk("start_busy_b", b_busy, 1);
    chk("start_bc_a", a_bc, 0);     chk("start_ck_a", a_ck, 0);
    chk("start_done_a", a_done, 0); chk("start_ovf_b", b_ovf, 0);
  endtask

  task automatic strobe(input int addr, input logic [7:0] d, input bit drop);
    bit ina, inb;
    ina = addr < 16; inb = addr < 16384;
    ioctl_wr = 1'b1; ioctl_addr = 25'(addr); ioctl_dout = d;
    if (drop) ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("wr_a", a_wr, ina); chk("wr_b", b_wr, inb); chk("wait_a", a_wait, 0);
    if (ina) begin
      chk("waddr_a", a_addr, addr); chk("wdin_a", a_din, d);
      a_mem[addr] = d; a_known[addr] = 1; e_cnt_a++; e_sum_a = (e_sum_a + d) % 65536;
      if (addr > a_hw) a_hw = addr;
    end else e_ovf_a = 1;
    if (inb) begin
      chk("waddr_b", b_addr, addr); chk("wdin_b", b_din, d);
      b_mem[addr] = d; b_known[addr] = 1; e_cnt_b++; e_sum_b = (e_sum_b + d) % 65536;
    end else e_ovf_b = 1;
  endtask

  task automatic finish_load();
    int start, cnt, e;
    ioctl_download = 1'b0;
    start = (a_hw < 0) ? 0 : a_hw + 1;
    cnt = 0; e = start;
    @(negedge clk);
    chk("end_done_b", b_done, 1); chk("end_busy_b", b_busy, 0); chk("end_wr_b", b_wr, 0);
    while (a_busy === 1'b1 && cnt < 40) begin
      chk("fill_wr", a_wr, 1); chk("fill_wait", a_wait, 1);
      chk("fill_addr", a_addr, e); chk("fill_din", a_din, 0);
      cnt++; e++;
      @(negedge clk);
    end
    chk("fill_len", cnt, 16 - start);
    chk("end_done_a", a_done, 1); chk("end_wr_a", a_wr, 0); chk("end_wait_a", a_wait, 0);
    for (int i = start; i < 16; i++) begin a_mem[i] = 8'h00; a_known[i] = 1; end
    chk("bc_a", a_bc, e_cnt_a);   chk("ck_a", a_ck, e_sum_a);   chk("ovf_a", a_ovf, e_ovf_a);
    chk("bc_b", b_bc, e_cnt_b);   chk("ck_b", b_ck, e_sum_b);   chk("ovf_b", b_ovf, e_ovf_b);
  endtask

  task automatic mem_check();
    int m;
    m = 0;
    for (int i = 0; i < 16; i++) if (a_known[i] && shadow_a[i] !== a_mem[i]) m++;
    chk("ram_a_mismatches", m, 0);
    m = 0;
    for (int i = 0; i < 16384; i++) if (b_known[i] && shadow_b[i] !== b_mem[i]) m++;
    chk("ram_b_mismatches", m, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n, addr, r;
    logic [7:0] d;
    bit drop;

    // reset state
    model_clear();
    idle(3);
    chk_zero("reset");
    reset = 1'b0;
    idle(1);
    chk_zero("post_reset");

    // directed 4-byte load
    begin_load();
    strobe(0, 8'h11, 0); strobe(1, 8'h22, 0); idle(1);
    strobe(2, 8'h33, 0); strobe(3, 8'h44, 0);
    finish_load();
    chk("tp1_bc_b", b_bc, 4); chk("tp1_ck_b", b_ck, 16'h00AA); chk("tp1_ovf_b", b_ovf, 0);
    idle(2);
    chk("held_done_a", a_done, 1); chk("held_bc_a", a_bc, 4); chk("held_busy_a", a_busy, 0);
    mem_check();

    // strobe outside a load is ignored
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h77;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("idle_wr_a", a_wr, 0); chk("idle_wr_b", b_wr, 0); chk("idle_bc_b", b_bc, 4);

    // overflow strobes, last byte on the falling cycle
    begin_load();
    strobe(32'h4000, 8'h99, 0);
    chk("ovf_hold_bc_b", b_bc, 0); chk("ovf_set_b", b_ovf, 1);
    strobe(32'h20, 8'h5A, 0);
    strobe(7, 8'hC3, 1);
    finish_load();
    mem_check();

    // zero-byte download: full fill from 0
    begin_load();
    finish_load();
    chk("zero_bc_a", a_bc, 0); chk("zero_ck_a", a_ck, 0);
    mem_check();

    // reset during the fill
    begin_load();
    strobe(0, 8'hA1, 0); strobe(1, 8'hB2, 0);
    ioctl_download = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(a_wr === 1'b1 && a_addr === 4'd8) && n < 40);
    chk("rst_fill_reached", n < 40, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("mid_reset");
    for (int i = 2; i <= 8; i++) begin a_mem[i] = 8'h00; a_known[i] = 1; end
    @(negedge clk);
    chk("post_rst_wr_a", a_wr, 0); chk("post_rst_busy_a", a_busy, 0);
    mem_check();

    // new download abandons a running fill
    begin_load();
    strobe(0, 8'h01, 0); strobe(1, 8'h02, 0); strobe(2, 8'h03, 0);
    ioctl_download = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(a_wr === 1'b1 && a_addr === 4'd5) && n < 40);
    chk("restart_fill_reached", n < 40, 1);
    for (int i = 3; i <= 5; i++) begin a_mem[i] = 8'h00; a_known[i] = 1; end
    ioctl_download = 1'b1;
    @(negedge clk);
    model_clear();
    chk("restart_busy_a", a_busy, 1); chk("restart_wr_a", a_wr, 0);
    chk("restart_wait_a", a_wait, 0); chk("restart_bc_a", a_bc, 0); chk("restart_ck_a", a_ck, 0);
    strobe(9, 8'hE7, 0); strobe(4, 8'h3C, 0);
    finish_load();
    mem_check();

    // randomized loads
    for (int it = 0; it < 8; it++) begin
      begin_load();
      n = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      addr = $urandom_range(0, 15);
        else if (r < 8) addr = $urandom_range(16, 16383);
        else            addr = $urandom_range(16384, 33554431);
        d = 8'($urandom);
        drop = (j == n - 1) && (addr < 16) && ($urandom_range(0, 1) == 1);
        strobe(addr, d, drop);
        if (!drop) idle($urandom_range(0, 2));
      end
      finish_load();
      mem_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
